// File: rtl/multi_param_key_controller.sv
// -----------------------------------------------------------------------------
// multi_param_key_controller
//
// Keyboard-driven adjuster for NUM_CH independent bounded parameters (volume,
// octave, tempo, instrument, ...). Each channel owns an up key and a down key,
// a [MIN, MAX] range, a default value and a saturate/wrap mode. Holding a key
// auto-repeats after REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles.
// KEY_DEFAULT restores every channel to its default.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   key_down     level map of currently held keys, indexed by key code
//   last_change  code of the most recently changed key
//   key_valid    one-cycle strobe, last_change valid this cycle
//   value        packed channel values, channel i at [VAL_W*i +: VAL_W]
//   changed      one-cycle pulse per channel, registered together with value
//   repeating    high while the auto-repeat engine is in its REPEAT phase
// -----------------------------------------------------------------------------
module multi_param_key_controller #(
  parameter int                      NUM_CH        = 2,
  parameter int                      VAL_W         = 3,
  parameter logic [9*NUM_CH-1:0]     KEY_UP        = {9'h01D, 9'h023},
  parameter logic [9*NUM_CH-1:0]     KEY_DN        = {9'h01B, 9'h01C},
  parameter logic [NUM_CH*VAL_W-1:0] MIN_VALS      = {3'd1, 3'd1},
  parameter logic [NUM_CH*VAL_W-1:0] MAX_VALS      = {3'd3, 3'd5},
  parameter logic [NUM_CH*VAL_W-1:0] RST_VALS      = {3'd2, 3'd3},
  parameter logic [NUM_CH-1:0]       WRAP_MASK     = 2'b00,
  parameter logic [8:0]              KEY_DEFAULT   = 9'h066,
  parameter int                      REPEAT_DELAY  = 50_000_000,
  parameter int                      REPEAT_PERIOD = 10_000_000,
  parameter int                      CNT_W         = 26
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [511:0]              key_down,
  input  logic [8:0]                last_change,
  input  logic                      key_valid,
  output logic [NUM_CH*VAL_W-1:0]   value,
  output logic [NUM_CH-1:0]         changed,
  output logic                      repeating
);

  // Hold-tracking FSM encoding.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  // Channel index width; a single-channel build still needs one bit.
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Terminal counts: the counter runs 0..LAST, so a step lands exactly
  // REPEAT_DELAY (or REPEAT_PERIOD) edges after the previous one.
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]              state_q,     state_d;
  logic [CNT_W-1:0]        cnt_q,       cnt_d;
  logic [8:0]              held_code_q, held_code_d;
  logic [CH_W-1:0]         held_ch_q,   held_ch_d;
  logic                    held_up_q,   held_up_d;
  logic [NUM_CH*VAL_W-1:0] value_q,     value_d;
  logic [NUM_CH-1:0]       changed_q,   changed_d;

  // ---------------------------------------------------------------------------
  // One bounded step. The limit is compared before any arithmetic, so the
  // VAL_W-bit increment/decrement can never overflow or underflow.
  // ---------------------------------------------------------------------------
  function automatic logic [VAL_W-1:0] step_value(
    input logic [VAL_W-1:0] cur,
    input logic [VAL_W-1:0] lo,
    input logic [VAL_W-1:0] hi,
    input logic             up,
    input logic             wrap
  );
    logic [VAL_W-1:0] res;
    if (up) begin
      if (cur >= hi) res = wrap ? lo : hi;
      else           res = cur + VAL_W'(1);
    end else begin
      if (cur <= lo) res = wrap ? hi : lo;
      else           res = cur - VAL_W'(1);
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Key decode: press detection and priority match.
  // The default key is checked first; otherwise the lowest channel wins and
  // within a channel the up key beats the down key.
  // ---------------------------------------------------------------------------
  logic            press_evt;
  logic            is_default;
  logic            match_found;
  logic [CH_W-1:0] match_ch;
  logic            match_up;

  // Release strobes carry a low key_down bit and must never step.
  assign press_evt  = key_valid && key_down[last_change];
  assign is_default = (last_change == KEY_DEFAULT);

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    match_found = 1'b0;
    match_ch    = '0;
    match_up    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!match_found) begin
        if (last_change == KEY_UP[9*i +: 9]) begin
          match_found = 1'b1;
          match_ch    = CH_W'(i);
          match_up    = 1'b1;
        end else if (last_change == KEY_DN[9*i +: 9]) begin
          match_found = 1'b1;
          match_ch    = CH_W'(i);
          match_up    = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic            do_step;
  logic [CH_W-1:0] step_ch;
  logic            step_up;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    held_code_d = held_code_q;
    held_ch_d   = held_ch_q;
    held_up_d   = held_up_q;
    value_d     = value_q;
    changed_d   = '0;
    do_step     = 1'b0;
    step_ch     = held_ch_q;
    step_up     = held_up_q;

    if (press_evt && is_default) begin
      // Restore defaults; only channels that actually move report a change.
      value_d = RST_VALS;
      for (int i = 0; i < NUM_CH; i++) begin
        changed_d[i] = (value_q[VAL_W*i +: VAL_W] != RST_VALS[VAL_W*i +: VAL_W]);
      end
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (press_evt && match_found) begin
      // A new matched press always takes over, from any state, and steps
      // immediately; any repeat step due this cycle is dropped.
      held_code_d = last_change;
      held_ch_d   = match_ch;
      held_up_d   = match_up;
      do_step     = 1'b1;
      step_ch     = match_ch;
      step_up     = match_up;
      cnt_d       = '0;
      state_d     = S_DELAY;
    end else begin
      // Unmatched presses and release strobes land here and leave the hold
      // alone; only the held key's own level can end it.
      case (state_q)
        S_IDLE: begin
        end
        S_DELAY: begin
          if (!key_down[held_code_q]) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DELAY_LAST) begin
            do_step = 1'b1;
            cnt_d   = '0;
            state_d = S_REPEAT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_REPEAT: begin
          if (!key_down[held_code_q]) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == PERIOD_LAST) begin
            // A step against a saturated limit keeps repeating with no change.
            do_step = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Apply the (single) step to the selected channel.
    for (int i = 0; i < NUM_CH; i++) begin
      if (do_step && (step_ch == CH_W'(i))) begin
        value_d[VAL_W*i +: VAL_W] = step_value(value_q[VAL_W*i +: VAL_W],
                                               MIN_VALS[VAL_W*i +: VAL_W],
                                               MAX_VALS[VAL_W*i +: VAL_W],
                                               step_up, WRAP_MASK[i]);
        changed_d[i] = (value_d[VAL_W*i +: VAL_W] != value_q[VAL_W*i +: VAL_W]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      held_code_q <= '0;
      held_ch_q   <= '0;
      held_up_q   <= 1'b0;
      value_q     <= RST_VALS;
      changed_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      held_code_q <= held_code_d;
      held_ch_q   <= held_ch_d;
      held_up_q   <= held_up_d;
      value_q     <= value_d;
      changed_q   <= changed_d;
    end
  end

  assign value     = value_q;
  assign changed   = changed_q;
  assign repeating = (state_q == S_REPEAT);

endmodule

// File: doc/multi_param_key_controller.md
Name: multi_param_key_controller

Overview:
- Keyboard-driven adjuster for NUM_CH independent bounded parameters (volume, octave, tempo, instrument, ...).
- Each channel has its own up/down key codes, limits, reset value and saturate/wrap mode.
- Holding a key auto-repeats; a dedicated key restores all defaults.
- Sits between the keyboard decoder (key_down/last_change/key_valid) and the tone/audio/display blocks.

Parameters:
- NUM_CH, 2, number of adjustable channels.
- VAL_W, 3, width of each channel value.
- KEY_UP, {9'h01D, 9'h023}, packed NUM_CH x 9 up-key codes; channel i in bits [9i+8:9i]. Default: ch1 = W, ch0 = D.
- KEY_DN, {9'h01B, 9'h01C}, packed down-key codes. Default: ch1 = S, ch0 = A.
- MIN_VALS, {3'd1, 3'd1}, packed NUM_CH x VAL_W per-channel minimum.
- MAX_VALS, {3'd3, 3'd5}, packed per-channel maximum. Requires MIN <= MAX.
- RST_VALS, {3'd2, 3'd3}, packed per-channel reset/default value, within [MIN, MAX].
- WRAP_MASK, 2'b00, bit i = 1: channel i wraps at its limits; 0: saturates.
- KEY_DEFAULT, 9'h066, key code that restores all channels to RST_VALS (Backspace).
- REPEAT_DELAY, 50_000_000, hold cycles before the first repeat step.
- REPEAT_PERIOD, 10_000_000, cycles between subsequent repeat steps.
- CNT_W, 26, repeat counter width; must hold max(REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- key_down  in  512  level map of currently held keys.
- last_change  in  9  code of the most recently changed key.
- key_valid  in  1  one-cycle strobe: last_change is valid this cycle.
- value  out  NUM_CH*VAL_W  packed channel values; channel i in bits [VAL_W*i+VAL_W-1:VAL_W*i].
- changed  out  NUM_CH  one-cycle pulse per channel, asserted when that channel's value changed on this clock edge.
- repeating  out  1  high while the FSM is in REPEAT.

Behaviour:
- Reset (async): value = RST_VALS, changed = 0, repeating = 0, FSM = IDLE, counter = 0, held key cleared.
- Press event: key_valid && key_down[last_change] in the same cycle. Release strobes (key_down bit low) never trigger a step.
- Key match order:
  - KEY_DEFAULT first.
  - Otherwise scan channel 0 upward; within a channel, KEY_UP before KEY_DN.
  - The first match wins; at most one channel steps per cycle.
- Step rules, applied at the clock edge after the event cycle (1-cycle latency; changed[i] is registered with value):
  - Up at MAX: saturate channel holds MAX with changed = 0; wrap channel goes to MIN with changed = 1.
  - Down at MIN: saturate channel holds MIN with changed = 0; wrap channel goes to MAX with changed = 1.
  - Otherwise +1 or -1, changed = 1.
  - All arithmetic is VAL_W-bit unsigned; no intermediate overflow is permitted (compare before increment).
- KEY_DEFAULT press: every channel loads its RST_VALS; changed[i] = 1 only where the value differs; FSM -> IDLE.
- FSM states: IDLE, DELAY, REPEAT. held_code (9b), held_ch, held_dir are registered.
  - IDLE: on an up/down press event, latch code/channel/direction, apply the step, counter = 0 -> DELAY.
  - DELAY: if key_down[held_code] == 0 -> IDLE. Else counter++. When counter == REPEAT_DELAY-1: step, counter = 0 -> REPEAT.
  - REPEAT: if key_down[held_code] == 0 -> IDLE. Else counter++. When counter == REPEAT_PERIOD-1: step, counter = 0.
  - In DELAY or REPEAT, a new matched up/down press event takes over: latch the new key, step immediately, counter = 0 -> DELAY. A release is checked before the takeover; the new press takes precedence when both occur in the same cycle.
  - Unmatched key press events are ignored and do not disturb the hold.
  - A repeat step on a saturated limit gives changed = 0 but keeps repeating.
- A repeat step and a new press event never both apply in one cycle; the press event wins.
- rst asserted mid-hold aborts immediately to the reset state; the key must be pressed again after reset to step.

Test Plan:
- Reset, no keys -> value = {3'd2, 3'd3}, changed = 0, repeating = 0.
- Tap D (press strobe with key_down[0x23] = 1, release 2 cycles later) three times -> ch0 goes 3→4→5→5; changed[0] pulses twice only; ch1 stays 2.
- Override WRAP_MASK = 2'b10; tap W twice from reset -> ch1 goes 2→3→1, changed[1] pulses both times; tap S once -> 3.
- Override REPEAT_DELAY = 8, REPEAT_PERIOD = 4; hold A for 30 cycles from reset -> ch0 steps at cycle 1 (3→2), at cycle 9 (2→1), then holds 1 with repeating = 1; release -> IDLE within 1 cycle.
- While holding D in REPEAT, press W -> ch1 steps immediately, hold retargets to W with a fresh DELAY, and ch0 stops stepping.
- Set ch0 = 5 and ch1 = 3, press Backspace -> value = {2, 3}, changed = 2'b11, FSM in IDLE. Assert rst mid-DELAY -> outputs return to reset values that same cycle.
